// File: rtl/ysyx_23060332_idu_pipe_pkg.sv
// Shared decode constants for the IDU: opcodes, func3/funct7 values,
// special instruction words, immediate types and halt FSM states.
package ysyx_23060332_idu_pipe_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_BR_RSV0 = 3'b010;
  localparam logic [2:0] F3_BR_RSV1 = 3'b011;
  localparam logic [2:0] F3_FENCE   = 3'b000;
  localparam logic [2:0] F3_JALR    = 3'b000;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } idu_state_e;

endpackage

// File: rtl/ysyx_23060332_idu_pipe_imm_gen.sv
// Combinational RV32I immediate generator, sign-extended to XLEN.
module ysyx_23060332_imm_gen
  import ysyx_23060332_idu_pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:7]     inst_i,
  input  imm_type_e       type_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (type_i)
      IMM_I:   imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      IMM_S:   imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B:   imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                        inst_i[11:8], 1'b0};
      IMM_U:   imm32 = {inst_i[31:12], 12'b0};
      IMM_J:   imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                        inst_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/ysyx_23060332_idu_pipe.sv
// RV32I decode stage with one-entry output register, halt FSM and decode counter.
// Optional M extension legality: define YSYX_23060332_M_EXT_EN.
module ysyx_23060332_idu_pipe
  import ysyx_23060332_idu_pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst_i,
  input  logic [XLEN-1:0]  pc_i,
  output logic [4:0]       raddr1,
  output logic [4:0]       raddr2,
  input  logic [XLEN-1:0]  rdata1,
  input  logic [XLEN-1:0]  rdata2,
  input  logic             flush_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  op1,
  output logic [XLEN-1:0]  op2,
  output logic [XLEN-1:0]  op1_jump,
  output logic [XLEN-1:0]  op2_jump,
  output logic [XLEN-1:0]  rs2_data,
  output logic             reg_wen,
  output logic [4:0]       waddr,
  output logic [31:0]      inst_o,
  output logic [XLEN-1:0]  pc_o,
  output logic             illegal_o,
  output logic             ebreak_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] dec_cnt
);

`ifdef YSYX_23060332_M_EXT_EN
  localparam bit M_EXT = 1'b1;
`else
  localparam bit M_EXT = 1'b0;
`endif

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opcode = inst_i[6:0];
  assign f3     = inst_i[14:12];
  assign f7     = inst_i[31:25];

  imm_type_e       imm_sel;
  logic [XLEN-1:0] imm;

  always_comb begin
    imm_sel = IMM_I;
    case (opcode)
      OPC_LUI, OPC_AUIPC: imm_sel = IMM_U;
      OPC_JAL:            imm_sel = IMM_J;
      OPC_BRANCH:         imm_sel = IMM_B;
      OPC_STORE:          imm_sel = IMM_S;
      default:            imm_sel = IMM_I;
    endcase
  end

  ysyx_23060332_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst_i (inst_i[31:7]),
    .type_i (imm_sel),
    .imm_o  (imm)
  );

  logic            legal, is_ebreak, use_rs1, use_rs2, wen_d;
  logic [XLEN-1:0] op1_d, op2_d, op1j_d, op2j_d, st_d;

  always_comb begin
    legal     = 1'b0;
    is_ebreak = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    wen_d     = 1'b0;
    op1_d     = '0;
    op2_d     = '0;
    op1j_d    = '0;
    op2j_d    = '0;
    st_d      = '0;
    case (opcode)
      OPC_LUI: begin
        legal = 1'b1; wen_d = 1'b1; op1_d = imm;
      end
      OPC_AUIPC: begin
        legal = 1'b1; wen_d = 1'b1; op1_d = pc_i; op2_d = imm;
      end
      OPC_JAL: begin
        legal = 1'b1; wen_d = 1'b1;
        op1_d = pc_i; op2_d = XLEN'(4); op1j_d = pc_i; op2j_d = imm;
      end
      OPC_JALR: begin
        legal = (f3 == F3_JALR); wen_d = 1'b1; use_rs1 = 1'b1;
        op1_d = pc_i; op2_d = XLEN'(4); op1j_d = rdata1; op2j_d = imm;
      end
      OPC_BRANCH: begin
        legal = (f3 != F3_BR_RSV0) && (f3 != F3_BR_RSV1);
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        op1_d = rdata1; op2_d = rdata2; op1j_d = pc_i; op2j_d = imm;
      end
      OPC_LOAD: begin
        legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        wen_d = 1'b1; use_rs1 = 1'b1; op1_d = rdata1; op2_d = imm;
      end
      OPC_STORE: begin
        legal = f3 inside {3'b000, 3'b001, 3'b010};
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        op1_d = rdata1; op2_d = imm; st_d = rdata2;
      end
      OPC_OP_IMM: begin
        if (f3 == F3_SLL)          legal = (f7 == F7_BASE);
        else if (f3 == F3_SRL_SRA) legal = (f7 == F7_BASE) || (f7 == F7_ALT);
        else                       legal = 1'b1;
        wen_d = 1'b1; use_rs1 = 1'b1; op1_d = rdata1; op2_d = imm;
      end
      OPC_OP: begin
        legal = (f7 == F7_BASE)
             || ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA)))
             || (M_EXT && (f7 == F7_MULDIV));
        wen_d = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        op1_d = rdata1; op2_d = rdata2;
      end
      OPC_MISC_MEM: legal = (f3 == F3_FENCE);
      OPC_SYSTEM: begin
        is_ebreak = (inst_i == INST_EBREAK);
        legal     = is_ebreak || (inst_i == INST_ECALL);
      end
      default: legal = 1'b0;
    endcase
    // Illegal encodings collapse to an inert bundle with only the trap flag set.
    if (!legal) begin
      is_ebreak = 1'b0;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      wen_d     = 1'b0;
      op1_d     = '0;
      op2_d     = '0;
      op1j_d    = '0;
      op2j_d    = '0;
      st_d      = '0;
    end
  end

  assign raddr1 = use_rs1 ? inst_i[19:15] : 5'd0;
  assign raddr2 = use_rs2 ? inst_i[24:20] : 5'd0;

  idu_state_e state_q, state_d;
  logic       out_valid_q;
  logic       accept;

  assign in_ready = !rst && !flush_i && (state_q == ST_RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    if ((state_q == ST_RUN) && accept && (!legal || is_ebreak)) state_d = ST_HALT;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  logic [XLEN-1:0]  op1_q, op2_q, op1j_q, op2j_q, st_q, pc_q;
  logic             wen_q, illegal_q, ebreak_q;
  logic [4:0]       waddr_q;
  logic [31:0]      inst_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      op1j_q      <= '0;
      op2j_q      <= '0;
      st_q        <= '0;
      pc_q        <= '0;
      wen_q       <= 1'b0;
      waddr_q     <= '0;
      inst_q      <= '0;
      illegal_q   <= 1'b0;
      ebreak_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (flush_i)        out_valid_q <= 1'b0;
      else if (accept)    out_valid_q <= 1'b1;
      else if (out_ready) out_valid_q <= 1'b0;
      if (accept) begin
        op1_q     <= op1_d;
        op2_q     <= op2_d;
        op1j_q    <= op1j_d;
        op2j_q    <= op2j_d;
        st_q      <= st_d;
        pc_q      <= pc_i;
        wen_q     <= wen_d;
        waddr_q   <= wen_d ? inst_i[11:7] : 5'd0;
        inst_q    <= inst_i;
        illegal_q <= !legal;
        ebreak_q  <= is_ebreak;
        cnt_q     <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign op1       = op1_q;
  assign op2       = op2_q;
  assign op1_jump  = op1j_q;
  assign op2_jump  = op2j_q;
  assign rs2_data  = st_q;
  assign reg_wen   = wen_q;
  assign waddr     = waddr_q;
  assign inst_o    = inst_q;
  assign pc_o      = pc_q;
  assign illegal_o = illegal_q;
  assign ebreak_o  = ebreak_q;
  assign halted_o  = (state_q == ST_HALT);
  assign dec_cnt   = cnt_q;

endmodule

// File: tb/tb_ysyx_23060332_idu_pipe.sv
// Directed self-checking bench for ysyx_23060332_idu_pipe (XLEN=32).
module tb_ysyx_23060332_idu_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush_i, out_valid, out_ready;
  logic [31:0] inst_i, pc_i, rdata1, rdata2;
  logic [4:0]  raddr1, raddr2, waddr;
  logic [31:0] op1, op2, op1_jump, op2_jump, rs2_data, inst_o, pc_o, dec_cnt;
  logic        reg_wen, illegal_o, ebreak_o, halted_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  ysyx_23060332_idu_pipe #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst_i(inst_i), .pc_i(pc_i), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .flush_i(flush_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .op1(op1), .op2(op2), .op1_jump(op1_jump), .op2_jump(op2_jump),
    .rs2_data(rs2_data), .reg_wen(reg_wen), .waddr(waddr),
    .inst_o(inst_o), .pc_o(pc_o), .illegal_o(illegal_o),
    .ebreak_o(ebreak_o), .halted_o(halted_o), .dec_cnt(dec_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction with out_ready=1, advance one edge, then idle the input.
  task automatic issue(input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    inst_i = inst; pc_i = pc; rdata1 = r1; rdata2 = r2;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("in_ready_before_accept", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    rdata1 = 32'hBAD0_BAD0; rdata2 = 32'hBAD1_BAD1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; flush_i = 1'b0; out_ready = 1'b0;
    inst_i = 32'h0000_0013; pc_i = '0; rdata1 = '0; rdata2 = '0;
    #1;
    chk("in_ready_in_rst", in_ready, 1'b0);
    step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_dec_cnt", dec_cnt, 32'd0);
    chk("rst_halted", halted_o, 1'b0);
    chk("rst_op1", op1, 32'd0);
    rst = 1'b0; in_valid = 1'b0;

    // addi x1,x2,-1
    inst_i = 32'hFFF1_0093; #1;
    chk("addi_raddr1", raddr1, 5'd2);
    chk("addi_raddr2", raddr2, 5'd0);
    issue(32'hFFF1_0093, 32'h8000_0000, 32'd5, 32'd77);
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_op1", op1, 32'd5);
    chk("addi_op2", op2, 32'hFFFF_FFFF);
    chk("addi_wen", reg_wen, 1'b1);
    chk("addi_waddr", waddr, 5'd1);
    chk("addi_illegal", illegal_o, 1'b0);
    chk("addi_cnt", dec_cnt, 32'd1);

    // beq x3,x4,-8 back-to-back with the addi consume
    issue(32'hFE41_8CE3, 32'h8000_0010, 32'h11, 32'h22);
    chk("beq_valid", out_valid, 1'b1);
    chk("beq_op1", op1, 32'h11);
    chk("beq_op2", op2, 32'h22);
    chk("beq_op1j", op1_jump, 32'h8000_0010);
    chk("beq_op2j", op2_jump, 32'hFFFF_FFF8);
    chk("beq_wen", reg_wen, 1'b0);
    chk("beq_waddr", waddr, 5'd0);
    chk("beq_pc", pc_o, 32'h8000_0010);
    chk("beq_cnt", dec_cnt, 32'd2);

    // Stall three cycles with lui x5,0x12345 pending
    inst_i = 32'h1234_52B7; pc_i = 32'h8000_0020; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", in_ready, 1'b0);
      step();
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_op1j", op1_jump, 32'h8000_0010);
      chk("stall_inst", inst_o, 32'hFE41_8CE3);
      chk("stall_cnt", dec_cnt, 32'd2);
    end
    out_ready = 1'b1; #1;
    chk("release_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("lui_op1", op1, 32'h1234_5000);
    chk("lui_op2", op2, 32'd0);
    chk("lui_waddr", waddr, 5'd5);
    chk("lui_cnt", dec_cnt, 32'd3);
    step();
    chk("consume_only_valid", out_valid, 1'b0);

    // sw x6,12(x7)
    inst_i = 32'h0063_A623; #1;
    chk("sw_raddr1", raddr1, 5'd7);
    chk("sw_raddr2", raddr2, 5'd6);
    issue(32'h0063_A623, 32'h8000_0030, 32'h100, 32'hDEAD);
    chk("sw_op1", op1, 32'h100);
    chk("sw_op2", op2, 32'hC);
    chk("sw_rs2_data", rs2_data, 32'hDEAD);
    chk("sw_wen", reg_wen, 1'b0);

    // jal x1,+16: bit 24 is set, but rs2 is unused so raddr2 must read 0
    inst_i = 32'h0100_00EF; #1;
    chk("jal_raddr2", raddr2, 5'd0);
    issue(32'h0100_00EF, 32'h8000_0100, 32'h0, 32'h0);
    chk("jal_op1", op1, 32'h8000_0100);
    chk("jal_op2", op2, 32'd4);
    chk("jal_op1j", op1_jump, 32'h8000_0100);
    chk("jal_op2j", op2_jump, 32'h10);
    chk("jal_waddr", waddr, 5'd1);

    // auipc x2,0xFFFFF
    issue(32'hFFFF_F117, 32'h8000_0200, 32'h0, 32'h0);
    chk("auipc_op1", op1, 32'h8000_0200);
    chk("auipc_op2", op2, 32'hFFFF_F000);
    chk("auipc_waddr", waddr, 5'd2);

    // jalr x1,-4(x5)
    issue(32'hFFC2_80E7, 32'h8000_0300, 32'h1000, 32'h0);
    chk("jalr_op1", op1, 32'h8000_0300);
    chk("jalr_op2", op2, 32'd4);
    chk("jalr_op1j", op1_jump, 32'h1000);
    chk("jalr_op2j", op2_jump, 32'hFFFF_FFFC);

    // canonical nop
    issue(32'h0000_0013, 32'h8000_0304, 32'h0, 32'h0);
    chk("nop_illegal", illegal_o, 1'b0);
    chk("nop_wen", reg_wen, 1'b1);
    chk("nop_waddr", waddr, 5'd0);
    chk("nop_cnt", dec_cnt, 32'd8);

    // flush with a held bundle and a pending instruction
    issue(32'h0050_0093, 32'h8000_0308, 32'h0, 32'h0);
    chk("pre_flush_valid", out_valid, 1'b1);
    chk("pre_flush_cnt", dec_cnt, 32'd9);
    flush_i = 1'b1; in_valid = 1'b1; out_ready = 1'b1; inst_i = 32'h0000_0013; #1;
    chk("flush_in_ready", in_ready, 1'b0);
    step();
    flush_i = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_cnt", dec_cnt, 32'd9);

    // mul x3,x1,x2
    issue(32'h0220_81B3, 32'h8000_0400, 32'h6, 32'h7);
`ifdef YSYX_23060332_M_EXT_EN
    chk("mul_illegal", illegal_o, 1'b0);
    chk("mul_op1", op1, 32'h6);
    chk("mul_op2", op2, 32'h7);
    chk("mul_wen", reg_wen, 1'b1);
    chk("mul_halted", halted_o, 1'b0);
`else
    chk("mul_illegal", illegal_o, 1'b1);
    chk("mul_op1", op1, 32'h0);
    chk("mul_wen", reg_wen, 1'b0);
    chk("mul_halted", halted_o, 1'b1);
`endif
    chk("mul_valid", out_valid, 1'b1);

    // reset in the middle of a held bundle
    out_ready = 1'b0; rst = 1'b1; in_valid = 1'b1; #1;
    chk("midrst_in_ready", in_ready, 1'b0);
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_cnt", dec_cnt, 32'd0);
    chk("midrst_halted", halted_o, 1'b0);
    chk("midrst_op1", op1, 32'd0);

    // OP funct7=0100000 with func3=001 is not a base encoding
    issue(32'h4000_1033, 32'h8000_0500, 32'h3, 32'h4);
    chk("ill_illegal", illegal_o, 1'b1);
    chk("ill_valid", out_valid, 1'b1);
    chk("ill_wen", reg_wen, 1'b0);
    chk("ill_op2", op2, 32'd0);
    chk("ill_halted", halted_o, 1'b1);
    in_valid = 1'b1; inst_i = 32'h0000_0013; out_ready = 1'b1; #1;
    chk("ill_in_ready", in_ready, 1'b0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("flush_in_halt", halted_o, 1'b1);
    chk("halt_cnt", dec_cnt, 32'd1);

    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("rst_leaves_halt", halted_o, 1'b0);

    // ebreak
    issue(32'h0010_0073, 32'h8000_0600, 32'h0, 32'h0);
    chk("ebreak_flag", ebreak_o, 1'b1);
    chk("ebreak_illegal", illegal_o, 1'b0);
    chk("ebreak_valid", out_valid, 1'b1);
    chk("ebreak_halted", halted_o, 1'b1);
    in_valid = 1'b1; inst_i = 32'h0000_0013; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("halt_in_ready", in_ready, 1'b0);
      step();
    end
    chk("halt_hold_cnt", dec_cnt, 32'd1);
    chk("halt_drained", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
